// File: rtl/rt_cmd_scheduler.sv
// Time-ordered real-time command queue feeding the MASTER_START synchronizer.
// Optional stale-entry discard is compiled in with `define STALE_DROP_EN.
module rt_cmd_scheduler #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = 274,
  parameter int unsigned GUARD = 64
) (
  input  logic                    clk_48,
  input  logic                    rst_n,
  input  logic                    spi_wr,
  input  logic [63:0]             time_start,
  input  logic [PW-1:0]           payload,
  input  logic                    req_comm,
  input  logic [63:0]             sys_time,
  input  logic                    sys_time_update,
  output logic                    data_wr,
  output logic [63:0]             time_start_z,
  output logic [PW-1:0]           payload_z,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    empty,
  output logic                    full,
  output logic                    ovf,
  output logic                    drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CHK, S_ISS} state_t;

  state_t              state, state_n;
  logic                spi_wr_q, req_q, upd_q;
  logic                wr_edge, req_edge, flush;
  logic                pend;
  logic                pop, push, load_z, stale, stale_hit;
  logic [AW:0]         wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
  logic [AW-1:0]       wr_addr;
  logic [63:0]         deadline;
  logic [63:0]         stage_ts;
  logic [PW-1:0]       stage_pl;
  logic [PW+63:0]      mem [DEPTH];

  assign wr_edge  = spi_wr & ~spi_wr_q;
  assign req_edge = req_comm & ~req_q;
  assign flush    = sys_time_update & ~upd_q;

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      spi_wr_q <= 1'b0;
      req_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      spi_wr_q <= spi_wr;
      req_q    <= req_comm;
      upd_q    <= sys_time_update;
    end
  end

  assign deadline = sys_time + 64'(GUARD);

`ifdef STALE_DROP_EN
  assign stale = (stage_ts <= deadline);
`else
  logic unused_deadline;
  assign unused_deadline = ^deadline;
  assign stale = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_n   = state;
    pop       = 1'b0;
    load_z    = 1'b0;
    stale_hit = 1'b0;
    case (state)
      S_IDLE: if (pend && !empty) state_n = S_RD;
      S_RD: begin
        pop     = 1'b1;
        state_n = S_CHK;
      end
      S_CHK: begin
        if (stale) begin
          stale_hit = 1'b1;
          state_n   = empty ? S_IDLE : S_RD;
        end else begin
          load_z  = 1'b1;
          state_n = S_ISS;
        end
      end
      S_ISS:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // A re-based time invalidates anything in flight, including a pending issue.
    if (flush) begin
      state_n   = S_IDLE;
      pop       = 1'b0;
      load_z    = 1'b0;
      stale_hit = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    wr_addr  = wr_ptr[AW-1:0];
    push     = 1'b0;
    if (flush) begin
      // Flush first, then a same-cycle write lands in slot 0.
      rd_ptr_n = '0;
      wr_addr  = '0;
      push     = wr_edge;
      wr_ptr_n = wr_edge ? PTR_ONE : '0;
    end else begin
      if (pop) rd_ptr_n = rd_ptr + PTR_ONE;
      push = wr_edge & (~full | pop);
      if (push) wr_ptr_n = wr_ptr + PTR_ONE;
    end
    level_n = wr_ptr_n - rd_ptr_n;
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pend   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      drop   <= 1'b0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      empty  <= (level_n == '0);
      full   <= (level_n == LVL_FULL);
      ovf    <= wr_edge & ~push;
      drop   <= stale_hit;
      if (flush)               pend <= req_edge;
      else if (state == S_ISS) pend <= 1'b0;
      else if (req_edge)       pend <= 1'b1;
    end
  end

  // NOTE: the entry array is deliberately not reset; pointers alone define which slots are valid.
  always_ff @(posedge clk_48) begin
    if (push) mem[wr_addr] <= {time_start, payload};
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      stage_ts     <= '0;
      stage_pl     <= '0;
      data_wr      <= 1'b0;
      time_start_z <= '0;
      payload_z    <= '0;
    end else begin
      if (pop) {stage_ts, stage_pl} <= mem[rd_ptr[AW-1:0]];
      data_wr <= load_z;
      if (load_z) begin
        time_start_z <= stage_ts;
        payload_z    <= stage_pl;
      end
    end
  end

endmodule
